// File: rtl/mcpu_core_pkg.sv
// rtl/mcpu_core_pkg.sv - shared MCPU core constants and debug FSM encoding
package mcpu_core_pkg;

  localparam int LANES_DEF  = 4;
  localparam int NREGS_DEF  = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NPREDS_DEF = 3;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_WAIT = 2'd1,
    DBG_ACK  = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/mcpu_core_regfile_scoreboard.sv
// rtl/mcpu_core_regfile_scoreboard.sv - per-register busy bits, claim sets and clear resets
module mcpu_core_regfile_scoreboard
  import mcpu_core_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      claim_we,
  input  logic [LANES*RW-1:0]   claim_num,
  input  logic [NREGS-1:0]      clear,
  output logic [NREGS-1:0]      busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_vec;
  logic [RW-1:0]    claim_idx;

  // Decode claims; a claim wins over a clear of the same register in one cycle
  always_comb begin
    set_vec   = '0;
    claim_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      claim_idx = claim_num[l*RW +: RW];
      if (claim_we[l] && (int'(claim_idx) < NREGS)) begin
        set_vec[claim_idx] = 1'b1;
      end
    end
    busy_d = (busy_q & ~clear) | set_vec;
  end

  // Busy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/mcpu_core_regfile_sb.sv
// rtl/mcpu_core_regfile_sb.sv - multi-lane register file with scoreboard, predicates and debug port
module mcpu_core_regfile_sb
  import mcpu_core_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NPREDS = NPREDS_DEF,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                    clkrst_core_clk,
  input  logic                    clkrst_core_rst_n,
  input  logic [LANES*RW-1:0]     d2rf_rs_num,
  input  logic [LANES*RW-1:0]     d2rf_rt_num,
  output logic [LANES*DATA_W-1:0] rf2d_rs_data,
  output logic [LANES*DATA_W-1:0] rf2d_rt_data,
  output logic [LANES-1:0]        rf2d_rs_busy,
  output logic [LANES-1:0]        rf2d_rt_busy,
  input  logic [LANES-1:0]        d2rf_claim_we,
  input  logic [LANES*RW-1:0]     d2rf_claim_num,
  input  logic [LANES*RW-1:0]     wb2rf_rd_num,
  input  logic [LANES*DATA_W-1:0] wb2rf_rd_data,
  input  logic [LANES-1:0]        wb2rf_rd_we,
  input  logic [LANES-1:0]        wb2rf_pred_we,
  output logic [NPREDS-1:0]       preds,
  input  logic                    dbg2rf_req,
  input  logic                    dbg2rf_we,
  input  logic [RW-1:0]           dbg2rf_num,
  input  logic [DATA_W-1:0]       dbg2rf_wdata,
  output logic                    rf2dbg_ack,
  output logic [DATA_W-1:0]       rf2dbg_rdata
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NPREDS-1:0] preds_q;
  logic [NPREDS-1:0] preds_d;
  dbg_state_e        state_q;
  dbg_state_e        state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  logic [RW-1:0]     rs_num_a  [LANES];
  logic [RW-1:0]     rt_num_a  [LANES];
  logic [RW-1:0]     wb_num_a  [LANES];
  logic [DATA_W-1:0] wb_data_a [LANES];

  logic              any_wb_we;
  logic              dbg_fire;
  logic [NREGS-1:0]  clear_vec;
  logic [NREGS-1:0]  busy;

  function automatic logic reg_ok(input logic [RW-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // Split packed per-lane buses into indexable arrays
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rs_num_a[l]  = d2rf_rs_num[l*RW +: RW];
      rt_num_a[l]  = d2rf_rt_num[l*RW +: RW];
      wb_num_a[l]  = wb2rf_rd_num[l*RW +: RW];
      wb_data_a[l] = wb2rf_rd_data[l*DATA_W +: DATA_W];
    end
  end

  assign any_wb_we = |wb2rf_rd_we;

  // Combinational read ports with writeback bypass; lowest matching lane is applied last so it wins
  always_comb begin
    rf2d_rs_data = '0;
    rf2d_rt_data = '0;
    rf2d_rs_busy = '0;
    rf2d_rt_busy = '0;
    for (int l = 0; l < LANES; l++) begin
      if (reg_ok(rs_num_a[l])) begin
        rf2d_rs_data[l*DATA_W +: DATA_W] = mem_q[rs_num_a[l]];
        rf2d_rs_busy[l] = busy[rs_num_a[l]];
        for (int w = LANES - 1; w >= 0; w--) begin
          if (wb2rf_rd_we[w] && (wb_num_a[w] == rs_num_a[l])) begin
            rf2d_rs_data[l*DATA_W +: DATA_W] = wb_data_a[w];
          end
        end
      end
      if (reg_ok(rt_num_a[l])) begin
        rf2d_rt_data[l*DATA_W +: DATA_W] = mem_q[rt_num_a[l]];
        rf2d_rt_busy[l] = busy[rt_num_a[l]];
        for (int w = LANES - 1; w >= 0; w--) begin
          if (wb2rf_rd_we[w] && (wb_num_a[w] == rt_num_a[l])) begin
            rf2d_rt_data[l*DATA_W +: DATA_W] = wb_data_a[w];
          end
        end
      end
    end
  end

  // Debug FSM: the access fires on the edge leaving IDLE or WAIT while no lane writes back
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    dbg_fire = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (dbg2rf_req) begin
          if (any_wb_we) begin
            state_d = DBG_WAIT;
          end else begin
            state_d  = DBG_ACK;
            dbg_fire = 1'b1;
          end
        end
      end
      DBG_WAIT: begin
        if (!any_wb_we) begin
          state_d  = DBG_ACK;
          dbg_fire = 1'b1;
        end
      end
      DBG_ACK: begin
        state_d = DBG_IDLE;
      end
      default: begin
        state_d = DBG_IDLE;
      end
    endcase
    if (dbg_fire && !dbg2rf_we) begin
      rdata_d = reg_ok(dbg2rf_num) ? mem_q[dbg2rf_num] : '0;
    end
  end

  // Next register contents, scoreboard clears and predicate updates
  always_comb begin
    mem_d     = mem_q;
    preds_d   = preds_q;
    clear_vec = '0;
    for (int w = LANES - 1; w >= 0; w--) begin
      if (wb2rf_rd_we[w] && reg_ok(wb_num_a[w])) begin
        mem_d[wb_num_a[w]]     = wb_data_a[w];
        clear_vec[wb_num_a[w]] = 1'b1;
      end
      if (wb2rf_pred_we[w] && (int'(wb_num_a[w][1:0]) < NPREDS)) begin
        preds_d[wb_num_a[w][1:0]] = wb_data_a[w][0];
      end
    end
    if (dbg_fire && dbg2rf_we && reg_ok(dbg2rf_num)) begin
      mem_d[dbg2rf_num]     = dbg2rf_wdata;
      clear_vec[dbg2rf_num] = 1'b1;
    end
  end

  // Architectural state and debug FSM registers
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      preds_q <= '0;
      state_q <= DBG_IDLE;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      preds_q <= preds_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  mcpu_core_regfile_scoreboard #(
    .LANES (LANES),
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clkrst_core_clk),
    .rst_n     (clkrst_core_rst_n),
    .claim_we  (d2rf_claim_we),
    .claim_num (d2rf_claim_num),
    .clear     (clear_vec),
    .busy      (busy)
  );

  assign preds        = preds_q;
  assign rf2dbg_ack   = (state_q == DBG_ACK);
  assign rf2dbg_rdata = rdata_q;

endmodule

// File: tb/tb_mcpu_core_regfile_sb.sv
// tb/tb_mcpu_core_regfile_sb.sv - directed self-checking bench for mcpu_core_regfile_sb
module tb_mcpu_core_regfile_sb;

  localparam int LANES  = 4;
  localparam int NREGS  = 32;
  localparam int DATA_W = 32;
  localparam int NPREDS = 3;
  localparam int RW     = 5;

  logic                    clk;
  logic                    rst_n;
  logic [LANES*RW-1:0]     rs_num;
  logic [LANES*RW-1:0]     rt_num;
  logic [LANES*DATA_W-1:0] rs_data;
  logic [LANES*DATA_W-1:0] rt_data;
  logic [LANES-1:0]        rs_busy;
  logic [LANES-1:0]        rt_busy;
  logic [LANES-1:0]        claim_we;
  logic [LANES*RW-1:0]     claim_num;
  logic [LANES*RW-1:0]     wb_num;
  logic [LANES*DATA_W-1:0] wb_data;
  logic [LANES-1:0]        wb_we;
  logic [LANES-1:0]        pred_we;
  logic [NPREDS-1:0]       preds;
  logic                    dbg_req;
  logic                    dbg_we;
  logic [RW-1:0]           dbg_num;
  logic [DATA_W-1:0]       dbg_wdata;
  logic                    dbg_ack;
  logic [DATA_W-1:0]       dbg_rdata;

  int checks;
  int failures;

  mcpu_core_regfile_sb dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .d2rf_rs_num       (rs_num),
    .d2rf_rt_num       (rt_num),
    .rf2d_rs_data      (rs_data),
    .rf2d_rt_data      (rt_data),
    .rf2d_rs_busy      (rs_busy),
    .rf2d_rt_busy      (rt_busy),
    .d2rf_claim_we     (claim_we),
    .d2rf_claim_num    (claim_num),
    .wb2rf_rd_num      (wb_num),
    .wb2rf_rd_data     (wb_data),
    .wb2rf_rd_we       (wb_we),
    .wb2rf_pred_we     (pred_we),
    .preds             (preds),
    .dbg2rf_req        (dbg_req),
    .dbg2rf_we         (dbg_we),
    .dbg2rf_num        (dbg_num),
    .dbg2rf_wdata      (dbg_wdata),
    .rf2dbg_ack        (dbg_ack),
    .rf2dbg_rdata      (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    claim_we = '0;
    claim_num = '0;
    wb_num = '0;
    wb_data = '0;
    wb_we = '0;
    pred_we = '0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_num = '0;
    dbg_wdata = '0;
  endtask

  task automatic set_wb(input int l, input logic [RW-1:0] num, input logic [DATA_W-1:0] data,
                        input logic we, input logic pwe);
    wb_num[l*RW +: RW] = num;
    wb_data[l*DATA_W +: DATA_W] = data;
    wb_we[l] = we;
    pred_we[l] = pwe;
  endtask

  task automatic set_rs(input int l, input logic [RW-1:0] num);
    rs_num[l*RW +: RW] = num;
  endtask

  task automatic set_rt(input int l, input logic [RW-1:0] num);
    rt_num[l*RW +: RW] = num;
  endtask

  task automatic set_claim(input int l, input logic [RW-1:0] num, input logic we);
    claim_num[l*RW +: RW] = num;
    claim_we[l] = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rs_num = '0;
    rt_num = '0;
    set_rs(0, 5'd1);
    set_rt(3, 5'd31);
    #12;
    checks++;
    if (preds !== 3'b000) begin failures++; $display("FAIL reset_preds: got %b expected 000", preds); end
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", dbg_ack); end
    checks++;
    if (dbg_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", dbg_rdata); end
    checks++;
    if (rs_busy !== 4'b0000 || rt_busy !== 4'b0000) begin
      failures++; $display("FAIL reset_busy: got rs=%b rt=%b expected 0000", rs_busy, rt_busy);
    end
    checks++;
    if (rs_data[31:0] !== 32'h0 || rt_data[127:96] !== 32'h0) begin
      failures++; $display("FAIL reset_data: got %h/%h expected 0", rs_data[31:0], rt_data[127:96]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multi_write();
    set_wb(0, 5'd5, 32'h11, 1'b1, 1'b0);
    set_wb(2, 5'd5, 32'h22, 1'b1, 1'b0);
    set_rs(1, 5'd5);
    #1;
    checks++;
    if (rs_data[63:32] !== 32'h11) begin
      failures++; $display("FAIL multi_bypass: got %h expected 00000011", rs_data[63:32]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs_data[63:32] !== 32'h11) begin
      failures++; $display("FAIL multi_commit: got %h expected 00000011", rs_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    set_rs(3, 5'd7);
    set_rt(0, 5'd7);
    #1;
    checks++;
    if (rs_data[127:96] !== 32'h0) begin
      failures++; $display("FAIL bypass_pre: got %h expected 0", rs_data[127:96]);
    end
    set_wb(1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    checks++;
    if (rs_data[127:96] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_rs: got %h expected deadbeef", rs_data[127:96]);
    end
    checks++;
    if (rt_data[31:0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_rt: got %h expected deadbeef", rt_data[31:0]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs_data[127:96] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_commit: got %h expected deadbeef", rs_data[127:96]);
    end
  endtask

  task automatic test_scoreboard();
    logic [3:0] exp_busy [7];
    exp_busy[0] = 1'b0; exp_busy[1] = 1'b1; exp_busy[2] = 1'b1; exp_busy[3] = 1'b1;
    exp_busy[4] = 1'b1; exp_busy[5] = 1'b1; exp_busy[6] = 1'b0;
    set_rs(2, 5'd9);
    set_rt(1, 5'd9);
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) set_claim(1, 5'd9, 1'b1);
      if (c == 3) begin
        set_claim(2, 5'd9, 1'b1);
        set_wb(0, 5'd9, 32'h99, 1'b1, 1'b0);
      end
      if (c == 5) set_wb(3, 5'd9, 32'h999, 1'b1, 1'b0);
      #1;
      checks++;
      if (rs_busy[2] !== exp_busy[c][0] || rt_busy[1] !== exp_busy[c][0]) begin
        failures++;
        $display("FAIL sb_busy_c%0d: got rs=%b rt=%b expected %b", c, rs_busy[2], rt_busy[1], exp_busy[c][0]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_preds();
    set_wb(0, 5'd3, 32'h1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (preds !== 3'b000) begin failures++; $display("FAIL pred_idx3: got %b expected 000", preds); end
    set_wb(0, 5'd2, 32'h1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (preds !== 3'b100) begin failures++; $display("FAIL pred_idx2: got %b expected 100", preds); end
    set_rs(0, 5'd2);
    #1;
    checks++;
    if (rs_data[31:0] !== 32'h0) begin failures++; $display("FAIL pred_no_regwrite: got %h expected 0", rs_data[31:0]); end
    set_wb(1, 5'd0, 32'h1, 1'b0, 1'b1);
    set_wb(3, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (preds !== 3'b101) begin failures++; $display("FAIL pred_lowest_lane: got %b expected 101", preds); end
  endtask

  task automatic test_debug_write();
    set_claim(0, 5'd4, 1'b1);
    tick();
    idle_inputs();
    set_rs(0, 5'd4);
    #1;
    checks++;
    if (rs_busy[0] !== 1'b1) begin failures++; $display("FAIL dbgw_preclaim: got %b expected 1", rs_busy[0]); end
    for (int c = 0; c < 5; c++) begin
      dbg_req = 1'b1;
      dbg_we = 1'b1;
      dbg_num = 5'd4;
      dbg_wdata = 32'hCAFE;
      wb_we = '0;
      if (c < 3) set_wb(0, 5'd10, 32'hA0 + c, 1'b1, 1'b0);
      #1;
      checks++;
      if (dbg_ack !== (c == 4)) begin
        failures++; $display("FAIL dbgw_ack_c%0d: got %b expected %b", c, dbg_ack, (c == 4));
      end
      if (c == 3) begin
        checks++;
        if (rs_data[31:0] !== 32'h0) begin failures++; $display("FAIL dbgw_early: got %h expected 0", rs_data[31:0]); end
      end
      if (c == 4) begin
        dbg_req = 1'b0;
        checks++;
        if (rs_data[31:0] !== 32'hCAFE) begin failures++; $display("FAIL dbgw_data: got %h expected cafe", rs_data[31:0]); end
        checks++;
        if (rs_busy[0] !== 1'b0) begin failures++; $display("FAIL dbgw_busy: got %b expected 0", rs_busy[0]); end
      end
      tick();
    end
    idle_inputs();
    set_rs(1, 5'd10);
    #1;
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbgw_ack_drop: got %b expected 0", dbg_ack); end
    checks++;
    if (rs_data[63:32] !== 32'hA2) begin failures++; $display("FAIL dbgw_lane_data: got %h expected a2", rs_data[63:32]); end
  endtask

  task automatic test_debug_read();
    logic [4:0]  nums [2];
    logic [31:0] exps [2];
    nums[0] = 5'd7; exps[0] = 32'hDEADBEEF;
    nums[1] = 5'd5; exps[1] = 32'h11;
    for (int k = 0; k < 2; k++) begin
      dbg_req = 1'b1;
      dbg_we = 1'b0;
      dbg_num = nums[k];
      #1;
      checks++;
      if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbgr_ack_early%0d: got %b expected 0", k, dbg_ack); end
      tick();
      checks++;
      if (dbg_ack !== 1'b1 || dbg_rdata !== exps[k]) begin
        failures++; $display("FAIL dbgr_data%0d: got ack=%b data=%h expected ack=1 data=%h", k, dbg_ack, dbg_rdata, exps[k]);
      end
      dbg_req = 1'b0;
      tick();
      checks++;
      if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbgr_ack_len%0d: got %b expected 0", k, dbg_ack); end
    end
    checks++;
    if (preds !== 3'b101) begin failures++; $display("FAIL dbgr_preds: got %b expected 101", preds); end
  endtask

  task automatic test_reset_mid_op();
    int acks;
    acks = 0;
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    dbg_num = 5'd12;
    dbg_wdata = 32'h1234;
    set_wb(0, 5'd20, 32'h55, 1'b1, 1'b0);
    tick();
    if (dbg_ack) acks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (dbg_ack) acks++;
    #3;
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dbg_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL rst_mid_ack: got %0d acks expected 0", acks); end
    set_rs(0, 5'd12);
    set_rs(1, 5'd7);
    #1;
    checks++;
    if (rs_data[31:0] !== 32'h0) begin failures++; $display("FAIL rst_mid_target: got %h expected 0", rs_data[31:0]); end
    checks++;
    if (rs_data[63:32] !== 32'h0 || preds !== 3'b000) begin
      failures++; $display("FAIL rst_mid_state: got r7=%h preds=%b expected 0/000", rs_data[63:32], preds);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_multi_write();
    test_bypass();
    test_scoreboard();
    test_preds();
    test_debug_write();
    test_debug_read();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
